// File: rtl/conv_pkg.sv
// Shared types and frame-size helpers for the convolution frame scheduler.
// No logic; no latency; no flow control.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_HDR,
    S_FETCH,
    S_SEND,
    S_DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_SEND,
    HS_WAIT_LO,
    HS_WAIT_HI
  } hs_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  function automatic int n_in(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int n_out(input int rows, input int cols, input int k);
    return (rows - k + 1) * (cols - k + 1);
  endfunction

endpackage

// File: rtl/tx_byte_hs.sv
// One-byte TX UART handshake: enable pulse on ready, then wait for ready low and high again.
// Latency: enable 2 cycles after go_i when TX is ready; done_o is combinational on ready return.
// Backpressure: waits indefinitely in SEND while tx_rdy_i is low; no enable is issued then.
module tx_byte_hs
  import conv_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  input  logic tx_rdy_i,
  output logic tx_enable_o,
  output logic done_o
);

  hs_state_t state_q;
  logic      tx_enable_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HS_IDLE;
      tx_enable_q <= 1'b0;
    end else begin
      tx_enable_q <= 1'b0;
      case (state_q)
        HS_IDLE:    if (go_i) state_q <= HS_SEND;
        HS_SEND: begin
          if (tx_rdy_i) begin
            tx_enable_q <= 1'b1;
            state_q     <= HS_WAIT_LO;
          end
        end
        // Ready still reads high the cycle after enable; the drop marks acceptance.
        HS_WAIT_LO: if (!tx_rdy_i) state_q <= HS_WAIT_HI;
        HS_WAIT_HI: if (tx_rdy_i) state_q <= HS_IDLE;
        default:    state_q <= HS_IDLE;
      endcase
    end
  end

  assign tx_enable_o = tx_enable_q;
  assign done_o      = (state_q == HS_WAIT_HI) && tx_rdy_i;

endmodule

// File: rtl/conv_frame_sched.sv
// Frame controller: admits one frame into the convolutor, counts results, drains them to TX.
// Latency: rx->conv_drdy combinational; 2-cycle fetch plus TX handshake per byte.
// Backpressure: TX ready handshake per byte; strobes outside their window set sticky overrun.
// FRAME_HDR_EN: send a 0xA5 header byte ahead of the result bytes.
module conv_frame_sched
  import conv_pkg::*;
#(
  parameter int ROW_DEPTH    = 7,
  parameter int COLUMN_DEPTH = 7,
  parameter int K_SIZE       = 3,
  parameter int D_BITS       = 8,
  localparam int N_IN        = n_in(ROW_DEPTH, COLUMN_DEPTH),
  localparam int N_OUT       = n_out(ROW_DEPTH, COLUMN_DEPTH, K_SIZE),
  localparam int AW          = $clog2(N_OUT)
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_rx_dvalid,
  output logic              o_conv_drdy,
  input  logic              i_conv_dvalid,
  output logic [AW-1:0]     o_rd_addr,
  input  logic [D_BITS-1:0] i_rd_data,
  output logic [D_BITS-1:0] o_tx_data,
  output logic              o_tx_enable,
  input  logic              i_tx_rdy,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overrun
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int OW = $clog2(N_OUT + 1);
  localparam logic [IW-1:0] IN_LAST   = IW'(N_IN - 1);
  localparam logic [IW-1:0] IN_FULL   = IW'(N_IN);
  localparam logic [OW-1:0] OUT_FULL  = OW'(N_OUT);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N_OUT - 1);

  sched_state_t      state_q;
  logic [IW-1:0]     in_cnt_q;
  logic [OW-1:0]     out_cnt_q;
  logic [AW-1:0]     rd_idx_q;
  logic [D_BITS-1:0] tx_data_q;
  logic              fetch_ph_q;
  logic              hs_go_q;
  logic              frame_done_q;
  logic              overrun_q;

  logic in_load, conv_ok, start_ok, rx_err, conv_err, hs_done;

  assign in_load  = (state_q == S_LOAD);
  assign conv_ok  = (in_load || state_q == S_CONV) && (out_cnt_q != OUT_FULL);
  assign start_ok = i_start && (state_q == S_IDLE || state_q == S_DONE);
  assign rx_err   = i_rx_dvalid && !in_load;
  assign conv_err = i_conv_dvalid && !conv_ok;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      rd_idx_q     <= '0;
      tx_data_q    <= '0;
      fetch_ph_q   <= 1'b0;
      hs_go_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      hs_go_q      <= 1'b0;

      // A stray strobe in the same cycle as an accepted start still flags overrun.
      if (start_ok)          overrun_q <= 1'b0;
      if (rx_err || conv_err) overrun_q <= 1'b1;

      if (i_conv_dvalid && conv_ok) out_cnt_q <= out_cnt_q + 1'b1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q    <= S_LOAD;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            rd_idx_q   <= '0;
            fetch_ph_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (i_rx_dvalid && in_cnt_q != IN_FULL) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == IN_LAST) state_q <= S_CONV;
          end
        end
        S_CONV: begin
          if (out_cnt_q == OUT_FULL) begin
`ifdef FRAME_HDR_EN
            state_q   <= S_HDR;
            tx_data_q <= D_BITS'(HDR_BYTE);
            hs_go_q   <= 1'b1;
`else
            state_q   <= S_FETCH;
`endif
          end
        end
        S_HDR: if (hs_done) state_q <= S_FETCH;
        S_FETCH: begin
          // First cycle presents the address, second captures the memory's registered data.
          if (fetch_ph_q) begin
            fetch_ph_q <= 1'b0;
            tx_data_q  <= i_rd_data;
            hs_go_q    <= 1'b1;
            state_q    <= S_SEND;
          end else begin
            fetch_ph_q <= 1'b1;
          end
        end
        S_SEND: begin
          if (hs_done) begin
            if (rd_idx_q == ADDR_LAST) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  tx_byte_hs u_tx_hs (
    .clk_i       (i_clk),
    .rst_i       (reset),
    .go_i        (hs_go_q),
    .tx_rdy_i    (i_tx_rdy),
    .tx_enable_o (o_tx_enable),
    .done_o      (hs_done)
  );

  assign o_conv_drdy  = i_rx_dvalid && in_load;
  assign o_rd_addr    = rd_idx_q;
  assign o_tx_data    = tx_data_q;
  assign o_busy       = !(state_q == S_IDLE || state_q == S_DONE);
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_conv_frame_sched.sv
// Bench for conv_frame_sched: vector table, reset/abort sequence, directed and random frames.
// Memory and TX UART are behavioural models; expected bytes come straight from the memory image.
module tb_conv_frame_sched;

  localparam int N_IN  = 49;
  localparam int N_OUT = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, rx = 1'b0, conv = 1'b0, tx_rdy = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic       drdy, tx_en, busy, frame_done, overrun;
  logic [4:0] rd_addr;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  conv_frame_sched #(.ROW_DEPTH(7), .COLUMN_DEPTH(7), .K_SIZE(3), .D_BITS(8)) dut (
    .i_clk         (clk),
    .reset         (rst),
    .i_start       (start),
    .i_rx_dvalid   (rx),
    .o_conv_drdy   (drdy),
    .i_conv_dvalid (conv),
    .o_rd_addr     (rd_addr),
    .i_rd_data     (rd_data),
    .o_tx_data     (tx_data),
    .o_tx_enable   (tx_en),
    .i_tx_rdy      (tx_rdy),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .o_overrun     (overrun)
  );

  int total = 0, bad = 0;
  int en_cnt = 0, done_cnt = 0, en_lo_cnt = 0;
  int tx_dly = 10, tx_cnt = 0;
  bit hold_lo = 1'b0;
  logic [7:0] mem [32];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  // Pixel memory: registered read, data valid one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  // TX UART: drops ready on enable, raises it tx_dly cycles later unless held low.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (tx_en) begin
      en_cnt++;
      got.push_back(tx_data);
      if (!tx_rdy) en_lo_cnt++;
      tx_rdy = 1'b0;
      tx_cnt = tx_dly;
    end else if (hold_lo) begin
      tx_rdy = 1'b0;
    end else if (!tx_rdy) begin
      if (tx_cnt == 0) tx_rdy = 1'b1;
      else tx_cnt--;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_drdy"}, drdy, 0);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
  endtask

  task automatic run_frame(input bit rnd, input int dly, input bit x_rx, input bit x_conv,
                           input bit fin_start, input bit hold, input bit mid_start);
    int rs, cs, cyc;
    bit did;
    logic [7:0] g;
    tx_dly = dly;
    exp_q.delete();
    got.delete();
    for (int i = 0; i < N_OUT; i++) mem[i] = 8'($urandom);
`ifdef FRAME_HDR_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(mem[i]);
    en_cnt = 0; done_cnt = 0; en_lo_cnt = 0;
    hold_lo = hold;

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ovr_clr", overrun, 0);

    rs = 0; cs = 0;
    while (rs < N_IN || cs < N_OUT) begin
      rx    = (rs < N_IN) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      conv  = (cs < N_OUT) && (rnd ? ($urandom_range(0, 2) == 0) : (rs >= 24));
      start = fin_start && rx && (rs == N_IN - 1);
      #1 chk("load_drdy", drdy, rx);
      if (rx) rs++;
      if (conv) cs++;
      tick;
    end
    rx = 1'b0; conv = 1'b0; start = 1'b0;

    if (x_rx) begin
      rx = 1'b1;
      #1 chk("extra_rx_drdy", drdy, 0);
      tick;
      rx = 1'b0;
    end
    if (x_conv) begin
      conv = 1'b1;
      tick;
      conv = 1'b0;
    end

    if (hold) begin
      repeat (100) tick;
      chk("hold_no_en", en_cnt, 0);
      chk("hold_busy", busy, 1);
      hold_lo = 1'b0;
    end

    did = 1'b0; cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      start = mid_start && !did && (en_cnt == 3);
      if (start) did = 1'b1;
      tick;
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    chk("frame_timeout", (done_cnt != 0), 1);
    repeat (5) tick;

    chk("done_pulses", done_cnt, 1);
    chk("en_count", en_cnt, exp_q.size());
    chk("en_rdy_lo", en_lo_cnt, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      chk($sformatf("byte%0d", i), g, exp_q[i]);
    end
    chk("end_busy", busy, 0);
    chk("end_ovr", overrun, (x_rx || x_conv));
  endtask

  typedef struct {
    bit start, rx, conv;
    bit e_drdy, e_ovr, e_busy;
  } vec_t;
  vec_t vt [7];

  initial begin
    // {start, rx, conv, drdy now, overrun after edge, busy after edge}
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk_reset_vals("por");

    for (int i = 0; i < 7; i++) begin
      start = vt[i].start; rx = vt[i].rx; conv = vt[i].conv;
      #1 chk($sformatf("vec%0d_drdy", i), drdy, vt[i].e_drdy);
      tick;
      start = 1'b0; rx = 1'b0; conv = 1'b0;
      chk($sformatf("vec%0d_ovr", i), overrun, vt[i].e_ovr);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
    end

    // Abort mid-LOAD after 20 bytes.
    for (int i = 0; i < 17; i++) begin
      rx = 1'b1;
      tick;
    end
    rx = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_busy", busy, 0);
    tick;
    rst = 1'b0;
    chk_reset_vals("rst_mid");
    rx = 1'b1;
    #1 chk("idle_drdy", drdy, 0);
    tick;
    rx = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_ovr", overrun, 1);
    repeat (3) tick;
    chk("idle_stays", busy, 0);

    // Directed: 10-cycle TX, 50th rx byte, start coinciding with final byte.
    run_frame(1'b0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Directed: TX ready held low 100 cycles, start during SEND, late conv result.
    run_frame(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    for (int f = 0; f < 6; f++)
      run_frame(1'b1, $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b0, 1'b0, 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
